// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bus arbiter.
package cart_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WACK, WDONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int         WACK_TIMEOUT  = 4;
  localparam logic [7:0] CART_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/cart_arb_req.sv
// Per-master request latch: captures one rd/wr strobe and holds it pending
// until the arbiter issues it.
module cart_arb_req
  import cart_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  input  logic          wr,
  input  logic          busy,
  input  logic          clr,
  output logic          pend,
  output logic [AW-1:0] lat_addr,
  output logic [DW-1:0] lat_wdata,
  output op_t           lat_op
);

  // clr only targets the granted master, whose busy is high, so it never
  // coincides with a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_op    <= OP_RD;
    end else if ((rd | wr) && !busy) begin
      pend      <= 1'b1;
      lat_addr  <= addr;
      lat_wdata <= wdata;
      lat_op    <= wr ? OP_WR : OP_RD;
    end else if (clr) begin
      pend      <= 1'b0;
    end
  end

endmodule

// File: rtl/cart_bus_arb.sv
// Two-master arbiter in front of cart_iface: DMG core (m0) and spicart (m1).
// Define CART_ARB_RR_EN for round-robin on ties; default is fixed m0 > m1.
module cart_bus_arb
  import cart_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rd,
  input  logic          m0_wr,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_busy,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rd,
  input  logic          m1_wr,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_busy,
  output logic [AW-1:0] cif_addr,
  output logic [DW-1:0] cif_din,
  input  logic [DW-1:0] cif_dout,
  output logic          cif_rd,
  output logic          cif_wr,
  input  logic          cif_busy
);

  logic          pend0, pend1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  op_t           op0, op1, op_g, op_sel;
  state_t        state, state_nxt;
  logic          grant, sel, active;
  logic          issue_go, done_ok, done_tmo;
  logic          clr0, clr1;
  logic [2:0]    tmo_cnt;
  logic [DW-1:0] rdata_ret;

  assign active  = (state != IDLE);
  assign m0_busy = pend0 | (active & ~grant);
  assign m1_busy = pend1 | (active &  grant);
  assign clr0    = (state == ISSUE) & ~grant;
  assign clr1    = (state == ISSUE) &  grant;
  assign op_g    = grant ? op1 : op0;
  assign op_sel  = sel ? op1 : op0;

  cart_arb_req #(.AW(AW), .DW(DW)) u_req0 (
    .clk, .rst, .addr(m0_addr), .wdata(m0_wdata), .rd(m0_rd), .wr(m0_wr),
    .busy(m0_busy), .clr(clr0), .pend(pend0), .lat_addr(addr0),
    .lat_wdata(wdata0), .lat_op(op0)
  );

  cart_arb_req #(.AW(AW), .DW(DW)) u_req1 (
    .clk, .rst, .addr(m1_addr), .wdata(m1_wdata), .rd(m1_rd), .wr(m1_wr),
    .busy(m1_busy), .clr(clr1), .pend(pend1), .lat_addr(addr1),
    .lat_wdata(wdata1), .lat_op(op1)
  );

`ifdef CART_ARB_RR_EN
  // last remembers the winner of the most recent tie; reset favours m0.
  logic last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           last <= 1'b1;
    else if (issue_go && pend0 && pend1) last <= sel;
  end
  assign sel = (pend0 & pend1) ? ~last : ~pend0;
`else
  assign sel = ~pend0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_go  = 1'b0;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      IDLE:
        if ((pend0 | pend1) && !cif_busy) begin
          state_nxt = ISSUE;
          issue_go  = 1'b1;
        end
      ISSUE: state_nxt = WACK;
      WACK:
        if (cif_busy) begin
          state_nxt = WDONE;
        end else if (tmo_cnt == 3'(WACK_TIMEOUT - 1)) begin
          state_nxt = IDLE;
          done_tmo  = 1'b1;
        end
      WDONE:
        if (!cif_busy) begin
          state_nxt = IDLE;
          done_ok   = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  // A cartridge that never answers reads as open bus.
  assign rdata_ret = done_ok ? cif_dout : DW'(CART_OPEN_BUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= 1'b0;
      cif_addr <= '0;
      cif_din  <= '0;
      cif_rd   <= 1'b0;
      cif_wr   <= 1'b0;
      tmo_cnt  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      cif_rd  <= 1'b0;
      cif_wr  <= 1'b0;
      tmo_cnt <= (state == WACK) ? tmo_cnt + 3'd1 : 3'd0;
      if (issue_go) begin
        grant    <= sel;
        cif_addr <= sel ? addr1 : addr0;
        cif_din  <= sel ? wdata1 : wdata0;
        cif_rd   <= (op_sel == OP_RD);
        cif_wr   <= (op_sel == OP_WR);
      end
      if ((done_ok | done_tmo) && op_g == OP_RD) begin
        if (grant) m1_rdata <= rdata_ret;
        else       m0_rdata <= rdata_ret;
      end
    end
  end

endmodule

// File: tb/tb_cart_bus_arb.sv
// Self-checking bench for cart_bus_arb with a simple cart_iface stub that
// answers reads with addr[7:0].
module tb_cart_bus_arb;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_busy, m1_busy;
  logic [AW-1:0] cif_addr;
  logic [DW-1:0] cif_din, cif_dout;
  logic          cif_rd, cif_wr, cif_busy;

  cart_bus_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rd(m0_rd), .m0_wr(m0_wr),
    .m0_rdata(m0_rdata), .m0_busy(m0_busy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rd(m1_rd), .m1_wr(m1_wr),
    .m1_rdata(m1_rdata), .m1_busy(m1_busy),
    .cif_addr(cif_addr), .cif_din(cif_din), .cif_dout(cif_dout),
    .cif_rd(cif_rd), .cif_wr(cif_wr), .cif_busy(cif_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cyc = 0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  din;
  } acc_t;
  acc_t acc_q[$];

  // stub cart_iface
  int   stub_len  = 3;
  logic stub_dead = 1'b0;
  int   scnt;
  assign cif_busy = (scnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      scnt     <= 0;
      cif_dout <= '0;
    end else if ((cif_rd || cif_wr) && !stub_dead) begin
      scnt     <= stub_len;
      cif_dout <= cif_addr[7:0];
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && (cif_rd || cif_wr)) begin
      acc_q.push_back({cif_rd, cif_wr, cif_addr, cif_din});
      pulse_cyc <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic req(input int m, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d;
    end else begin
      m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic clr_in();
    m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int fc);
    fc = -1;
    for (int i = 0; i < bound; i++) begin
      if (!m0_busy && !m1_busy) begin
        fc = cyc;
        break;
      end
      step();
    end
    if (fc < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got timeout want idle");
    end
  endtask

  typedef struct {
    int          mst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_wr;
    logic [7:0]  exp_r0;
    logic [7:0]  exp_r1;
  } vec_t;

  vec_t vecs[6];

  // random-phase reference state, one slot per master
  logic       ov[2], iss[2], iwr[2];
  logic [15:0] ea[2];
  logic [7:0]  ed[2], mrd[2];

  initial begin
    int   t0, fc, hit;
    acc_t x;

    vecs[0] = '{1, 1'b1, 1'b0, 16'h0134, 8'h00, 1'b0, 8'h00, 8'h34};
    vecs[1] = '{0, 1'b0, 1'b1, 16'h2000, 8'h05, 1'b1, 8'h00, 8'h34};
    vecs[2] = '{0, 1'b1, 1'b0, 16'h00A7, 8'h00, 1'b0, 8'hA7, 8'h34};
    vecs[3] = '{0, 1'b1, 1'b1, 16'h3001, 8'h99, 1'b1, 8'hA7, 8'h34};
    vecs[4] = '{1, 1'b0, 1'b1, 16'h1234, 8'h42, 1'b1, 8'hA7, 8'h34};
    vecs[5] = '{1, 1'b1, 1'b0, 16'h8081, 8'h00, 1'b0, 8'hA7, 8'h81};

    // reset state
    step(); step();
    chk("rst_cif_rd", cif_rd, 0);
    chk("rst_cif_wr", cif_wr, 0);
    chk("rst_cif_addr", cif_addr, 0);
    chk("rst_cif_din", cif_din, 0);
    chk("rst_busy", {m0_busy, m1_busy}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b0;
    step(); step();
    chk("idle_busy", {m0_busy, m1_busy}, 0);

    // uncontended single transactions
    for (int i = 0; i < 6; i++) begin
      acc_q.delete();
      req(vecs[i].mst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      t0 = cyc;
      step();
      clr_in();
      chk($sformatf("v%0d_busy_rise", i), vecs[i].mst ? m1_busy : m0_busy, 1);
      wait_idle(40, fc);
      chk($sformatf("v%0d_n_acc", i), acc_q.size(), 1);
      if (acc_q.size() == 1) begin
        chk($sformatf("v%0d_rd", i), acc_q[0].rd, !vecs[i].exp_wr);
        chk($sformatf("v%0d_wr", i), acc_q[0].wr, vecs[i].exp_wr);
        chk($sformatf("v%0d_addr", i), acc_q[0].addr, vecs[i].addr);
        chk($sformatf("v%0d_din", i), acc_q[0].din, vecs[i].wdata);
      end
      chk($sformatf("v%0d_lat_issue", i), pulse_cyc - t0, 2);
      chk($sformatf("v%0d_lat_done", i), fc - t0, 6);
      chk($sformatf("v%0d_r0", i), m0_rdata, vecs[i].exp_r0);
      chk($sformatf("v%0d_r1", i), m1_rdata, vecs[i].exp_r1);
    end

    // contention: first tie always m0
    acc_q.delete();
    req(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    req(1, 1'b1, 1'b0, 16'h0200, 8'h00);
    step(); clr_in();
    wait_idle(60, fc);
    chk("tie1_n", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("tie1_first", acc_q[0].addr, 16'h0100);
      chk("tie1_second", acc_q[1].addr, 16'h0200);
    end
    acc_q.delete();
    req(0, 1'b1, 1'b0, 16'h0300, 8'h00);
    req(1, 1'b1, 1'b0, 16'h0400, 8'h00);
    step(); clr_in();
    wait_idle(60, fc);
    chk("tie2_n", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
`ifdef CART_ARB_RR_EN
      chk("tie2_first", acc_q[0].addr, 16'h0400);
      chk("tie2_second", acc_q[1].addr, 16'h0300);
`else
      chk("tie2_first", acc_q[0].addr, 16'h0300);
      chk("tie2_second", acc_q[1].addr, 16'h0400);
`endif
    end

    // strobe while busy is dropped
    acc_q.delete();
    req(1, 1'b1, 1'b0, 16'h0500, 8'h00);
    step();
    req(1, 1'b1, 1'b0, 16'h0600, 8'h00);
    step(); clr_in();
    wait_idle(40, fc);
    chk("drop_n", acc_q.size(), 1);
    if (acc_q.size() == 1) chk("drop_addr", acc_q[0].addr, 16'h0500);

    // cartridge never answers
    acc_q.delete();
    stub_dead = 1'b1;
    req(1, 1'b1, 1'b0, 16'h4000, 8'h00);
    t0 = cyc;
    step(); clr_in();
    wait_idle(40, fc);
    chk("tmo_lat", fc - t0, 7);
    chk("tmo_rdata", m1_rdata, 8'hFF);
    chk("tmo_n", acc_q.size(), 1);
    stub_dead = 1'b0;

    // reset in WDONE
    req(1, 1'b1, 1'b0, 16'h0010, 8'h00);
    step(); clr_in();
    step(); step(); step();
    chk("mid_busy_pre", m1_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_cif_rd", cif_rd, 0);
    chk("mid_cif_wr", cif_wr, 0);
    chk("mid_busy", {m0_busy, m1_busy}, 0);
    chk("mid_rdata", {m0_rdata, m1_rdata}, 0);
    step(); step();
    rst = 1'b0;
    step();
    acc_q.delete();
    req(1, 1'b1, 1'b0, 16'h0055, 8'h00);
    step(); clr_in();
    wait_idle(40, fc);
    chk("post_rst_rdata", m1_rdata, 8'h55);
    chk("post_rst_n", acc_q.size(), 1);

    // randomized traffic against a transaction-level model
    acc_q.delete();
    ov[0] = 0; ov[1] = 0; iss[0] = 0; iss[1] = 0;
    mrd[0] = 8'h00; mrd[1] = 8'h55;
    for (int c = 0; c < 460; c++) begin
      clr_in();
      for (int n = 0; n < 2; n++) begin
        logic        b;
        int          r;
        logic [15:0] a;
        logic [7:0]  d;
        b = n ? m1_busy : m0_busy;
        if (c < 400 && !b && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 2);
          a = 16'($urandom);
          d = 8'($urandom);
          req(n, r != 1, r != 0, a, d);
          ov[n] = 1'b1; iss[n] = 1'b0; iwr[n] = (r != 0); ea[n] = a; ed[n] = d;
        end
      end
      stub_len = $urandom_range(2, 4);
      step();
      while (acc_q.size() != 0) begin
        x = acc_q.pop_front();
        hit = -1;
        for (int n = 0; n < 2; n++)
          if (hit < 0 && ov[n] && !iss[n] && ea[n] == x.addr && iwr[n] == x.wr &&
              x.rd == !iwr[n] && ed[n] == x.din)
            hit = n;
        checks++;
        if (hit < 0) begin
          errors++;
          $display("FAIL rnd_acc: got rd=%0b wr=%0b addr=%0h din=%0h want a pending request",
                   x.rd, x.wr, x.addr, x.din);
        end else begin
          iss[hit] = 1'b1;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (ov[n] && !(n ? m1_busy : m0_busy)) begin
          chk($sformatf("rnd_issued_m%0d", n), iss[n], 1);
          if (!iwr[n]) mrd[n] = ea[n][7:0];
          chk($sformatf("rnd_rdata_m%0d", n), n ? m1_rdata : m0_rdata, mrd[n]);
          ov[n] = 1'b0;
        end
      end
    end
    chk("rnd_drained", {ov[0], ov[1]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/cart_bus_arb.md
Name: cart_bus_arb

Overview:
- Two-master arbiter directly upstream of cart_iface.
- Master 0 is the DMG core cartridge port; master 1 is spicart (debug/dump access over SPI).
- Captures single-cycle rd/wr strobes from each master and serialises them onto cart_iface's one rd/wr/busy port.
- Returns read data and a per-master busy to whichever master owns the access.

Parameters:
- AW, 16, address width (matches cart_iface addr)
- DW, 8, data width

Ports:
- clk  in  1  system clock (8 MHz domain, same as cart_iface clk_8m)
- rst  in  1  asynchronous, active-high reset
- m0_addr  in  AW  master 0 address, sampled on strobe cycle
- m0_wdata  in  DW  master 0 write data, sampled on strobe cycle
- m0_rd  in  1  master 0 read strobe, one cycle
- m0_wr  in  1  master 0 write strobe, one cycle
- m0_rdata  out  DW  master 0 read data
- m0_busy  out  1  master 0 transaction pending or active
- m1_addr, m1_wdata, m1_rd, m1_wr, m1_rdata, m1_busy  same as m0_*, for master 1 (spicart)
- cif_addr  out  AW  to cart_iface addr
- cif_din  out  DW  to cart_iface din (write data)
- cif_dout  in  DW  from cart_iface dout (read data)
- cif_rd  out  1  to cart_iface rd
- cif_wr  out  1  to cart_iface wr
- cif_busy  in  1  from cart_iface busy

Behaviour:
- Reset: all outputs 0; pending flags cleared; FSM in IDLE; last-grant = m1, so m0 wins the first tie.
- Capture:
  - rd or wr high while mN_busy=0 sets pend_N and latches addr, wdata and op.
  - If rd and wr are high together, it is a write.
  - A strobe while mN_busy=1 is dropped; no state change.
- mN_busy = pend_N | (FSM active and grant==N). It rises the cycle after the strobe (registered).
- FSM states: IDLE, ISSUE, WACK, WDONE.
  - IDLE: if any pend and cif_busy=0, select grant (see priority) and go to ISSUE.
  - ISSUE (1 cycle):
    - Drive cif_addr/cif_din from the granted latch, and pulse cif_rd or cif_wr for exactly this cycle.
    - Clear pend_grant; go to WACK.
  - WACK: wait for cif_busy=1, then go to WDONE. If cif_busy is still 0 after 4 cycles, treat the access as complete: go to IDLE and return rdata=0xFF.
  - WDONE: on cif_busy=0, for a read load mN_rdata <= cif_dout; go to IDLE.
- cif_addr/cif_din hold their value from ISSUE until the next ISSUE.
- mN_rdata is updated only on completion of a read by that master; otherwise it holds.
- Latency, uncontended: strobe at cycle T, cif strobe at T+2, and mN_busy falls the cycle after cif_busy falls.
- Priority without the optional feature: fixed, m0 over m1.
- A master may re-strobe the cycle its busy is observed low; capture is in the same cycle that IDLE may select it.
- Mid-operation reset: aborts immediately; cif_rd/cif_wr deassert asynchronously; pending requests are lost.

Optional Feature:
- Macro CART_ARB_RR_EN.
- Defined: round-robin. When both pend, grant the master that was not granted last. This prevents spicart starvation while the core is polling.
- Undefined: fixed priority m0 > m1; last-grant register not synthesised.

Decomposition:
- Shared package cart_pkg:
  - FSM state enum (IDLE/ISSUE/WACK/WDONE)
  - op enum (OP_RD, OP_WR)
  - WACK_TIMEOUT=4 constant
  - CART_OPEN_BUS=8'hFF constant
- One natural sub-module, cart_arb_req: per-master capture latch with pend flag. Instantiated twice.

Test Plan:
- Single read: m1_rd with m1_addr=0x0134; stub cart_iface returns addr[7:0] (busy 3 cycles) -> one cif_rd pulse at addr 0x0134, m1_rdata=0x34, m1_busy low after cif_busy falls.
- Single write: m0_wr with addr=0x2000, wdata=0x05 -> one cif_wr pulse, cif_din=0x05, m0_rdata unchanged.
- Contention: m0_rd 0x0100 and m1_rd 0x0200 in the same cycle -> 0x0100 issued first, then 0x0200.
  - RR_EN defined: a second simultaneous pair then serves m1 first.
  - RR_EN undefined: always m0 first.
- Dropped strobe and rd+wr: m1_rd while m1_busy=1 -> ignored, exactly one cif access. m0_rd+m0_wr together -> cif_wr only.
- Timeout: stub never raises cif_busy after m1_rd 0x4000 -> return to IDLE after 4 WACK cycles, m1_rdata=0xFF, m1_busy low.
- Reset mid-transfer: assert rst during WDONE -> cif_rd/cif_wr=0, both busy=0, rdata=0. After release, a new m1_rd 0x0055 completes with 0x55.
